// File: rtl/calendar_pkg.sv
// calendar_pkg: shared types, limits and helpers for the calendar date path.
//   cal_state_t    : set-mode FSM state encoding
//   DAY/MON/YEAR_W : field widths of the day, month and year counters
//   *_MAX          : largest legal value of each field
//   days_in_month  : month length for a 1..12 month; leap selects 29-day February
package calendar_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_DAY  = 2'd1,
        ST_SET_MON  = 2'd2,
        ST_SET_YEAR = 2'd3
    } cal_state_t;

    localparam int DAY_W  = 5;
    localparam int MON_W  = 5;
    localparam int YEAR_W = 7;

    localparam int DAY_MAX  = 31;
    localparam int MON_MAX  = 12;
    localparam int YEAR_MAX = 99;

    // Out-of-range months fall into the 31-day default so a stray value can
    // never produce a zero-length month.
    function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0] mon,
                                                       input logic             leap);
        logic [DAY_W-1:0] d;
        case (mon)
            5'd2:                    d = leap ? 5'd29 : 5'd28;
            5'd4, 5'd6, 5'd9, 5'd11: d = 5'd30;
            default:                 d = 5'd31;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/calendar_ctrl_month_days.sv
// month_days: combinational days-in-month lookup.
//   mon  in  5 : month 1..12
//   leap in  1 : year is a leap year (year[1:0]==0 within 2000..2099)
//   dim  out 5 : number of days in that month
module month_days
    import calendar_pkg::*;
(
    input  logic [MON_W-1:0] mon,
    input  logic             leap,
    output logic [DAY_W-1:0] dim
);

    assign dim = days_in_month(mon, leap);

endmodule

// File: rtl/calendar_ctrl.sv
// calendar_ctrl: date sequencer with a button-driven set mode.
//   clk, rst_n          : clock, asynchronous active-low reset
//   day_tick            : midnight pulse, advances the date in RUN only
//   btn_mode            : steps RUN -> SET_DAY -> SET_MON -> SET_YEAR -> RUN
//   btn_inc             : increments the field being edited (ignored in RUN)
//   blink_tick          : toggles the blink phase
//   cnt_day/mon/year    : registered date fields (1..31, 1..12, 0..99)
//   set_mode            : high in any SET state
//   blank_day/mon/year  : blank the field currently being edited (blink)
//   dbg_state           : current FSM state for observation
// All inputs are single-cycle pulses; each pulse sampled high on a clk edge
// produces exactly one action, visible on the outputs after that same edge.
module calendar_ctrl
    import calendar_pkg::*;
#(
    parameter int DAY_RST  = 1,
    parameter int MON_RST  = 1,
    parameter int YEAR_RST = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              day_tick,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic              blink_tick,
    output logic [DAY_W-1:0]  cnt_day,
    output logic [MON_W-1:0]  cnt_mon,
    output logic [YEAR_W-1:0] cnt_year,
    output logic              set_mode,
    output logic              blank_day,
    output logic              blank_mon,
    output logic              blank_year,
    output cal_state_t        dbg_state
);

    if (DAY_RST < 1 || DAY_RST > DAY_MAX) begin : g_bad_day_rst
        $error("calendar_ctrl: DAY_RST out of range");
    end
    if (MON_RST < 1 || MON_RST > MON_MAX) begin : g_bad_mon_rst
        $error("calendar_ctrl: MON_RST out of range");
    end
    if (YEAR_RST < 0 || YEAR_RST > YEAR_MAX) begin : g_bad_year_rst
        $error("calendar_ctrl: YEAR_RST out of range");
    end

    localparam logic [MON_W-1:0]  MON_LIM  = MON_W'(MON_MAX);
    localparam logic [YEAR_W-1:0] YEAR_LIM = YEAR_W'(YEAR_MAX);

    cal_state_t        state_q, state_n;
    logic              phase_q, phase_n;
    logic [DAY_W-1:0]  day_n;
    logic [MON_W-1:0]  mon_n, mon_edit;
    logic [YEAR_W-1:0] year_n, year_edit;
    logic [DAY_W-1:0]  dim_cur, dim_new;
    logic              tick_acc, inc_acc;

    // Mode beats inc; ticks only count while running.
    assign tick_acc = day_tick && (state_q == ST_RUN);
    assign inc_acc  = btn_inc && !btn_mode && (state_q != ST_RUN);

    // Candidate month/year after an edit, used to clamp the day in the same update.
    assign mon_edit  = (state_q == ST_SET_MON)  ? ((cnt_mon >= MON_LIM) ? 5'd1 : cnt_mon + 5'd1)
                                                : cnt_mon;
    assign year_edit = (state_q == ST_SET_YEAR) ? ((cnt_year >= YEAR_LIM) ? 7'd0 : cnt_year + 7'd1)
                                                : cnt_year;

    month_days u_dim_cur (.mon(cnt_mon),  .leap(cnt_year[1:0] == 2'd0),  .dim(dim_cur));
    month_days u_dim_new (.mon(mon_edit), .leap(year_edit[1:0] == 2'd0), .dim(dim_new));

    always_comb begin
        state_n = state_q;
        day_n   = cnt_day;
        mon_n   = cnt_mon;
        year_n  = cnt_year;
        phase_n = phase_q;

        if (btn_mode) begin
            case (state_q)
                ST_RUN:      state_n = ST_SET_DAY;
                ST_SET_DAY:  state_n = ST_SET_MON;
                ST_SET_MON:  state_n = ST_SET_YEAR;
                default:     state_n = ST_RUN;
            endcase
        end

        if (tick_acc) begin
            if (cnt_day >= dim_cur) begin
                day_n = 5'd1;
                if (cnt_mon >= MON_LIM) begin
                    mon_n  = 5'd1;
                    year_n = (cnt_year >= YEAR_LIM) ? 7'd0 : cnt_year + 7'd1;
                end else begin
                    mon_n = cnt_mon + 5'd1;
                end
            end else begin
                day_n = cnt_day + 5'd1;
            end
        end

        if (inc_acc) begin
            if (state_q == ST_SET_DAY) begin
                day_n = (cnt_day >= dim_cur) ? 5'd1 : cnt_day + 5'd1;
            end else begin
                mon_n  = mon_edit;
                year_n = year_edit;
                if (cnt_day > dim_new) day_n = dim_new;
            end
        end

        // Clearing the phase keeps a freshly entered or edited field visible.
        if (state_n != state_q || inc_acc) begin
            phase_n = 1'b0;
        end else if (blink_tick) begin
            phase_n = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            phase_q    <= 1'b0;
            cnt_day    <= DAY_W'(DAY_RST);
            cnt_mon    <= MON_W'(MON_RST);
            cnt_year   <= YEAR_W'(YEAR_RST);
            set_mode   <= 1'b0;
            blank_day  <= 1'b0;
            blank_mon  <= 1'b0;
            blank_year <= 1'b0;
        end else begin
            state_q    <= state_n;
            phase_q    <= phase_n;
            cnt_day    <= day_n;
            cnt_mon    <= mon_n;
            cnt_year   <= year_n;
            set_mode   <= (state_n != ST_RUN);
            blank_day  <= (state_n == ST_SET_DAY)  && phase_n;
            blank_mon  <= (state_n == ST_SET_MON)  && phase_n;
            blank_year <= (state_n == ST_SET_YEAR) && phase_n;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: doc/calendar_ctrl.md
# calendar_ctrl

Sequences the calendar date fields of the clock design: day, month (1..12) and two-digit year (2000..2099). Advances the date on a once-per-day tick from the time-of-day counter and runs a button-driven set-mode FSM. Feeds the month-field seven-segment decoder (`cnt_mon`, 5-bit, 1..12) and the matching day and year decoders. Produces per-field blanking so the field being edited blinks.

## Interface
- `DAY_RST`, default 1: day value after reset (1..31).
- `MON_RST`, default 1: month value after reset (1..12).
- `YEAR_RST`, default 24: year value after reset (0..99, meaning 20xx).
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `day_tick` in 1: one-cycle pulse at midnight rollover.
- `btn_mode` in 1: one-cycle debounced pulse that steps the mode.
- `btn_inc` in 1: one-cycle debounced pulse that increments the selected field.
- `blink_tick` in 1: one-cycle pulse, about 2 Hz, that toggles the blink phase.
- `cnt_day` out 5: current day, 1..31.
- `cnt_mon` out 5: current month, 1..12.
- `cnt_year` out 7: current year, 0..99.
- `set_mode` out 1: high in any SET state.
- `blank_day`, `blank_mon`, `blank_year` out 1 each: blank the matching display field when high.

## Operation
- **FSM states:** RUN, SET_DAY, SET_MON, SET_YEAR.
- **`btn_mode` transitions:** RUN→SET_DAY→SET_MON→SET_YEAR→RUN. No other transitions exist.
- **Date advance in RUN on `day_tick`:**
  - Day increments.
  - When day equals dim(mon, year), day returns to 1 and month increments.
  - Month 12 wraps to 1 and year increments.
  - Year 99 wraps to 0.
- **dim (days in month):**
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - February is 29 if year[1:0]==0, else 28. This rule is exact for 2000..2099.
- **`btn_inc` in SET_x:** increments field x with wrap.
  - Day: dim→1.
  - Month: 12→1.
  - Year: 99→0.
  - In RUN, `btn_inc` is ignored.
- **Clamp:** after any month or year change in set mode, if day > dim(new mon, new year), day becomes dim in the same update. Example: 31 Jan, inc month → 28 Feb (year 23) or 29 Feb (year 24).
- **`day_tick` in SET states:** dropped, not queued. The date is frozen while editing.
- **Simultaneous events:**
  - `btn_mode` together with `btn_inc`: mode wins and the inc is dropped.
  - `day_tick` in the same cycle as `btn_mode` from SET_YEAR: the tick is dropped, because the state was SET_YEAR in that cycle.
- **Blink phase:**
  - A 1-bit register toggles on `blink_tick`.
  - It clears to 0 on every state change and on every accepted `btn_inc`, so an edited value is visible immediately.
  - `blank_x` = (state==SET_x) && phase.
  - `set_mode` = (state != RUN).

## Timing
- **Registered outputs:** all outputs are registered. Any change is visible on the first `clk` edge after the input pulse is sampled, so latency is 1 cycle.
- **Reset values:** while `rst_n` is low, outputs are forced asynchronously to:
  - state RUN, `cnt_day`=DAY_RST, `cnt_mon`=MON_RST, `cnt_year`=YEAR_RST;
  - phase 0;
  - `set_mode`, `blank_day`, `blank_mon`, `blank_year` all 0.
- **Reset mid-edit:** reset asserted mid-edit discards the edit and returns to reset values.
- **Pulse inputs:** exactly one action per pulse. Back-to-back pulses on consecutive cycles each take effect, e.g. two `btn_inc` give +2.
- **Out-of-range values:** `cnt_*` never leave their legal ranges. Illegal DAY_RST/MON_RST values are a parameter error, checked by an elaboration assertion.

## Structure
- **Shared package `calendar_pkg`:**
  - state enum `cal_state_t`.
  - constants `MON_MAX`=12, `YEAR_MAX`=99, `DAY_MAX`=31.
  - field widths 5/5/7.
- **Sub-module `month_days`:** combinational (mon[4:0], leap) → dim[4:0]. It is instantiated twice:
  - once for the current date (advance and day wrap);
  - once for the post-edit month/year (clamp).
- **Top level:** FSM, the three counters, and the blink register.

## Test plan
- **Reset and month-end rollover:** reset with defaults → 01/01/24, RUN, all blanks 0. Then 30 `day_tick` pulses → 31/01/24; one more → 01/02/24.
- **Leap and year wrap:**
  - Start 28/02/24, `day_tick` → 29/02/24; `day_tick` → 01/03/24.
  - Start 28/02/23, `day_tick` → 01/03/23.
  - Start 31/12/99, `day_tick` → 01/01/00.
- **Set sequence:** `btn_mode` → SET_DAY, `set_mode`=1.
  - `blink_tick` → `blank_day`=1.
  - `btn_inc` → day+1 and `blank_day`=0.
  - Three more `btn_mode` pulses → RUN with `blank_*`=0.
- **Clamp:** 31/01/23, enter SET_MON, `btn_inc` → 28/02/23. Step to SET_YEAR, `btn_inc` → year 24, day stays 28.
- **Collisions:**
  - In SET_DAY, `day_tick` → no change.
  - `btn_mode` and `btn_inc` in the same cycle → state advances, value unchanged.
  - `rst_n` low mid-SET_MON → immediately RUN at reset date.
